i2c_regfile_slave: RTL
======================

# i2c_regfile_slave

Parametrised I2C target exposing a bank of NUM_REGS 8-bit registers to an external master over SCL/SDA, with a register pointer, auto-increment, and wrap-around.

- Reads return a coherent snapshot of live core values, such as position and status bytes.
- Writes surface as single-cycle strobes to the core.
- The block sits between the pad-level open-drain wiring and the design's data sources, and supersedes the fixed read-only slave.

## Interface
Parameters:
- I2C_ADDR, 7'h64: 7-bit target address; general call (0x00) is ignored.
- NUM_REGS, 8: number of 8-bit registers, 2..256; PTR_W = $clog2(NUM_REGS).
- WR_MASK, {NUM_REGS{1'b0}}: bit i = 1 makes register i writable.

Ports:
- clk, in, 1: system clock; single clock domain; must be ≥ 8× SCL frequency.
- rst_n, in, 1: asynchronous, active-low reset.
- scl_in, in, 1: SCL from pad, asynchronous.
- sda_in, in, 1: SDA from pad, asynchronous.
- sda_oe, out, 1: 1 pulls SDA low, 0 releases it; the pad drives a constant 0.
- reg_rd_data, in, NUM_REGS*8: live register values; register i is bits [8i+7:8i].
- reg_wr_en, out, 1: one-cycle write strobe.
- reg_wr_addr, out, PTR_W: register index of the write.
- reg_wr_data, out, 8: write data.
- i2c_state, out, 3: current FSM state, for debug.
- busy, out, 1: 1 from START to STOP.

## Operation
Line handling:
- SCL and SDA each pass through a 2-flop synchroniser.
- Edge detection then produces scl_rise, scl_fall, START (SDA falls while SCL high) and STOP (SDA rises while SCL high).

FSM states:
- IDLE=0, ADDR=1, ACK_ADDR=2, RX_BYTE=3, ACK_RX=4, TX_BYTE=5, ACK_TX=6, WAIT_STOP=7.

Common rules:
- START in any state → ADDR; the bit counter clears and the pointer is retained (repeated start).
- STOP in any state → IDLE with sda_oe=0.
- Data is sampled on scl_rise and driven on scl_fall, MSB first.

Address phase:
- ADDR shifts in 8 bits.
- Address match → ACK_ADDR; sda_oe=1 from the next scl_fall to the scl_fall after it.
- Mismatch → WAIT_STOP; SDA is never driven.

Write direction (R/W=0):
- The first RX_BYTE is the pointer.
  - Value < NUM_REGS: ACK, and the pointer loads.
  - Otherwise: NACK, pointer unchanged, → WAIT_STOP.
- Each subsequent byte is ACKed.
  - If WR_MASK[ptr]=1: reg_wr_en pulses for one clk on the scl_rise that samples bit 0, with reg_wr_addr=ptr.
  - If WR_MASK[ptr]=0: the byte is dropped silently.
  - Either way the pointer then increments.

Read direction (R/W=1):
- On the address-match cycle, all of reg_rd_data latches into a snapshot register.
- TX_BYTE shifts out snapshot[ptr]. A 0 bit sets sda_oe=1; a 1 bit sets sda_oe=0.
- ACK_TX: sda_oe=0 and the master's bit is sampled.
  - ACK → pointer increments, next byte.
  - NACK → WAIT_STOP.

Pointer arithmetic:
- Increment is modulo NUM_REGS; ptr NUM_REGS-1 wraps to 0.

Reset values:
- sda_oe=0, reg_wr_en=0, reg_wr_addr=0, reg_wr_data=0, i2c_state=IDLE, busy=0.
- Pointer=0, snapshot=0, synchroniser flops=1.

## Timing
- Pin-to-event latency: 3 clk (2 synchroniser flops plus 1 edge-detect flop).
- sda_oe updates within 1 clk of the detected scl_fall; all SDA changes happen while SCL is low.
- reg_wr_en is exactly one clk wide.
- reg_wr_addr and reg_wr_data are valid in the strobe cycle and hold until the next strobe.
- Snapshot capture is atomic. A read burst returns values from a single clk even if reg_rd_data changes mid-burst.
- Reset mid-transfer: sda_oe drops to 0 asynchronously and the FSM returns to IDLE.
- Simultaneous STOP and scl edge cannot occur, since SCL is high at STOP. START takes priority over any pending bit event.

## Structure
- Package i2c_pkg holds:
  - the state encoding constants;
  - ACK=1'b0 and NACK=1'b1;
  - RW_WRITE and RW_READ.
- Sub-module i2c_line_sync holds the synchronisers and the edge/START/STOP detectors. It outputs scl_rise, scl_fall, sda_s, start and stop.
- The top-level module holds the FSM, shift register, bit counter, pointer and snapshot.

## Test plan
All tests use I2C_ADDR=7'h64 (write 0xC8, read 0xC9), NUM_REGS=8 and WR_MASK=8'b0000_1100.

1. Write C8, 02, A5, 5A, STOP → all four bytes ACKed; reg_wr_en pulses twice, with (2, A5) then (3, 5A).
2. Write C8, 00, Sr, C9, read 3 bytes with reg0=20, reg1=10, reg2=C9; master ACK, ACK, NACK → returns 20, 10, C9; SDA released after the NACK; busy=0 after STOP.
3. Same read as test 2, but change reg1 to FF one clk after the address ACK → still returns 10.
4. Address byte AA, then C8, 09, STOP → both NACKed, sda_oe stays 0, pointer unchanged; a following valid transaction succeeds.
5. Pointer 07, Sr, C9, read 2 bytes → reg7 then reg0 (wrap); a write to reg0 is ACKed with no reg_wr_en pulse.
6. Assert rst_n low mid-TX_BYTE while sda_oe=1 → sda_oe=0 with no clk edge; i2c_state=0; the next transaction works.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-file target: FSM state encoding and
// bus-level constants for the acknowledge bit and the R/W direction bit.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ACK_ADDR  = 3'd2,
        ST_RX_BYTE   = 3'd3,
        ST_ACK_RX    = 3'd4,
        ST_TX_BYTE   = 3'd5,
        ST_ACK_TX    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } i2c_state_t;

    localparam logic ACK      = 1'b0;
    localparam logic NACK     = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Brings asynchronous SCL/SDA into the clk domain and derives one-cycle
// scl_rise/scl_fall pulses plus START/STOP conditions.
module i2c_line_sync
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start,
    output logic stop
);

    logic r_scl_meta, r_scl_sync, r_scl_prev;
    logic r_sda_meta, r_sda_sync, r_sda_prev;

    // Idle bus is high, so all flops reset to 1 to avoid phantom edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_meta <= scl_in;
            r_scl_sync <= r_scl_meta;
            r_scl_prev <= r_scl_sync;
            r_sda_meta <= sda_in;
            r_sda_sync <= r_sda_meta;
            r_sda_prev <= r_sda_sync;
        end
    end

    assign scl_rise = r_scl_sync & ~r_scl_prev;
    assign scl_fall = ~r_scl_sync & r_scl_prev;
    assign sda_s    = r_sda_sync;
    // SDA may only move while SCL is high for START/STOP; data changes happen with SCL low.
    assign start    = r_scl_sync & r_scl_prev & r_sda_prev & ~r_sda_sync;
    assign stop     = r_scl_sync & r_scl_prev & ~r_sda_prev & r_sda_sync;

endmodule

// File: rtl/i2c_regfile_slave.sv
// I2C target exposing NUM_REGS byte registers with an auto-incrementing,
// wrapping pointer; reads come from an atomic snapshot, writes become strobes.
module i2c_regfile_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0]          I2C_ADDR = 7'h64,
    parameter int                  NUM_REGS = 8,
    parameter logic [NUM_REGS-1:0] WR_MASK  = {NUM_REGS{1'b0}},
    localparam int                 PTR_W    = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    input  logic [NUM_REGS*8-1:0] reg_rd_data,
    output logic                  reg_wr_en,
    output logic [PTR_W-1:0]      reg_wr_addr,
    output logic [7:0]            reg_wr_data,
    output logic [2:0]            i2c_state,
    output logic                  busy
);

    localparam logic [8:0] NUM_REGS_L = 9'(NUM_REGS);

    logic w_scl_rise, w_scl_fall, w_sda_s, w_start, w_stop;

    i2c_line_sync u_line_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .scl_rise (w_scl_rise),
        .scl_fall (w_scl_fall),
        .sda_s    (w_sda_s),
        .start    (w_start),
        .stop     (w_stop)
    );

    i2c_state_t             r_state, w_state_next;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_shift;
    logic [PTR_W-1:0]       r_ptr;
    logic [NUM_REGS*8-1:0]  r_snapshot;
    logic                   r_rw, r_first, r_ack_seen, r_sda_oe;
    logic                   r_wr_en;
    logic [PTR_W-1:0]       r_wr_addr;
    logic [7:0]             r_wr_data;

    logic [7:0]             w_byte, w_snap_byte;
    logic [PTR_W-1:0]       w_ptr_inc;
    logic                   w_addr_hit, w_ptr_ok, w_last_bit;

    assign w_byte      = {r_shift[6:0], w_sda_s};
    assign w_snap_byte = r_snapshot[{r_ptr, 3'b000} +: 8];
    assign w_ptr_inc   = (r_ptr == PTR_W'(NUM_REGS - 1)) ? '0 : r_ptr + 1'b1;
    assign w_addr_hit  = (w_byte[7:1] == I2C_ADDR) && (w_byte[7:1] != 7'h00);
    assign w_ptr_ok    = {1'b0, w_byte} < NUM_REGS_L;
    assign w_last_bit  = w_scl_rise && (r_bit_cnt == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_start) begin
            w_state_next = ST_ADDR;
        end else if (w_stop) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_ADDR:     if (w_last_bit) w_state_next = w_addr_hit ? ST_ACK_ADDR : ST_WAIT_STOP;
                ST_ACK_ADDR: if (w_scl_fall && r_ack_seen)
                                 w_state_next = (r_rw == RW_READ) ? ST_TX_BYTE : ST_RX_BYTE;
                ST_RX_BYTE:  if (w_last_bit) w_state_next = (r_first && !w_ptr_ok) ? ST_WAIT_STOP : ST_ACK_RX;
                ST_ACK_RX:   if (w_scl_fall && r_ack_seen) w_state_next = ST_RX_BYTE;
                ST_TX_BYTE:  if (w_last_bit) w_state_next = ST_ACK_TX;
                ST_ACK_TX: begin
                    if (w_scl_rise && w_sda_s == NACK)  w_state_next = ST_WAIT_STOP;
                    else if (w_scl_fall && r_ack_seen)  w_state_next = ST_TX_BYTE;
                end
                default: ;
            endcase
        end
    end

    // ACK phases: the first scl_fall starts the acknowledge bit, the scl_rise
    // marks it as clocked, and the following scl_fall ends it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sda_oe   <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_ptr      <= '0;
            r_snapshot <= '0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_rw       <= RW_WRITE;
            r_first    <= 1'b0;
            r_ack_seen <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_start) begin
                r_bit_cnt <= '0;
                r_sda_oe  <= 1'b0;
            end else if (w_stop) begin
                r_sda_oe  <= 1'b0;
            end else begin
                case (r_state)
                    ST_ADDR: if (w_scl_rise) begin
                        r_shift   <= w_byte;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7 && w_addr_hit) begin
                            r_rw       <= w_byte[0];
                            r_first    <= 1'b1;
                            r_ack_seen <= 1'b0;
                            if (w_byte[0] == RW_READ) r_snapshot <= reg_rd_data;
                        end
                    end
                    ST_ACK_ADDR, ST_ACK_RX: begin
                        if (w_scl_rise) r_ack_seen <= 1'b1;
                        if (w_scl_fall) begin
                            if (!r_ack_seen) begin
                                r_sda_oe <= 1'b1;
                            end else begin
                                r_bit_cnt <= '0;
                                if (r_state == ST_ACK_ADDR && r_rw == RW_READ) begin
                                    r_shift  <= w_snap_byte;
                                    r_sda_oe <= ~w_snap_byte[7];
                                end else begin
                                    r_sda_oe <= 1'b0;
                                end
                            end
                        end
                    end
                    ST_RX_BYTE: if (w_scl_rise) begin
                        r_shift   <= w_byte;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_ack_seen <= 1'b0;
                            if (r_first) begin
                                if (w_ptr_ok) begin
                                    r_ptr   <= w_byte[PTR_W-1:0];
                                    r_first <= 1'b0;
                                end
                            end else begin
                                if (WR_MASK[r_ptr]) begin
                                    r_wr_en   <= 1'b1;
                                    r_wr_addr <= r_ptr;
                                    r_wr_data <= w_byte;
                                end
                                r_ptr <= w_ptr_inc;
                            end
                        end
                    end
                    ST_TX_BYTE: begin
                        if (w_scl_rise) begin
                            r_shift   <= {r_shift[6:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) r_ack_seen <= 1'b0;
                        end
                        if (w_scl_fall) r_sda_oe <= ~r_shift[7];
                    end
                    ST_ACK_TX: begin
                        if (w_scl_rise) begin
                            r_ack_seen <= 1'b1;
                            if (w_sda_s == ACK) r_ptr <= w_ptr_inc;
                        end
                        if (w_scl_fall) begin
                            if (!r_ack_seen) begin
                                r_sda_oe <= 1'b0;
                            end else begin
                                r_shift   <= w_snap_byte;
                                r_sda_oe  <= ~w_snap_byte[7];
                                r_bit_cnt <= '0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_oe      = r_sda_oe;
    assign reg_wr_en   = r_wr_en;
    assign reg_wr_addr = r_wr_addr;
    assign reg_wr_data = r_wr_data;
    assign i2c_state   = r_state;
    assign busy        = (r_state != ST_IDLE);

endmodule
